pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the PC and datapath width (legal range 16..64).
REQ-002 Parameter RESET_PC, default 32'h0000_3000, SHALL be the fetch address loaded on reset.
REQ-003 Parameter EXC_PC, default 32'h0000_4180, SHALL be the exception handler entry.
REQ-004 Parameters ADDR_LO/ADDR_HI, default 32'h0000_3000/32'h0000_6FFC, SHALL bound the legal fetch range (inclusive).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 stall  in  1  hold F_PC this cycle.
REQ-008 D_PC  in  WIDTH  PC of the instruction in decode.
REQ-009 NPCOp  in  3  decode control: 000 seq, 001 branch, 010 j/jal, 011 jr; other codes SHALL be treated as 000.
REQ-010 B_JP  in  1  branch condition true (used only when NPCOp=001).
REQ-011 RSdata  in  WIDTH  jr target.
REQ-012 IR26  in  26  instruction index; IR26[15:0] is the branch offset.
REQ-013 exc_req  in  1  exception redirect pulse.
REQ-014 eret_req  in  1  return-from-exception pulse.
REQ-015 EPC  in  WIDTH  eret target.
REQ-016 F_PC  out  WIDTH  current fetch address (registered).
REQ-017 PC8  out  WIDTH  D_PC+8 link value (combinational).
REQ-018 redirect  out  1  registered; high for the cycle after a non-sequential F_PC load.
REQ-019 pend_valid  out  1  a deferred decode redirect is buffered.
REQ-020 fetch_err  out  1  F_PC misaligned (F_PC[1:0]!=0) or outside [ADDR_LO,ADDR_HI].

Function
REQ-021 Decode target SHALL be: branch -> D_PC+4+(sign-extended IR26[15:0]<<2); j/jal -> {D_PC[WIDTH-1:28],IR26,2'b00}; jr -> RSdata; all arithmetic modulo 2^WIDTH.
REQ-022 A decode redirect SHALL be requested when NPCOp=010 or 011, or NPCOp=001 with B_JP=1.
REQ-023 Next-PC priority each cycle SHALL be: exc_req > eret_req > buffered redirect > live decode redirect > F_PC+4.
REQ-024 exc_req and eret_req SHALL load F_PC regardless of stall and SHALL clear the buffer.
REQ-025 When both exc_req and eret_req are high, F_PC SHALL load EXC_PC.
REQ-026 With stall=0 and no exception/eret, F_PC SHALL load the highest-priority source in the next cycle (1-cycle latency).
REQ-027 With stall=1 and a live decode redirect, the target SHALL be captured into the one-entry buffer and pend_valid set next cycle; F_PC SHALL hold.
REQ-028 A live redirect arriving while pend_valid=1 SHALL be ignored (first redirect wins).
REQ-029 Buffer SHALL be consumed and pend_valid cleared on the first cycle with stall=0; that cycle's live decode redirect SHALL be dropped.
REQ-030 States: IDLE (pend_valid=0), PEND (pend_valid=1); IDLE->PEND on stall&redirect&!exc&!eret; PEND->IDLE on !stall or exc or eret.
REQ-031 redirect SHALL assert only when F_PC is loaded from a non-sequential source (exc, eret, buffer, or live decode redirect).
REQ-032 fetch_err SHALL be combinational from F_PC; it SHALL NOT alter next-PC selection.
REQ-033 F_PC+4 SHALL wrap modulo 2^WIDTH without error flag.

Reset
REQ-034 On a rising edge with reset=0: F_PC=RESET_PC, pend_valid=0, redirect=0, state=IDLE; all other inputs ignored that cycle.
REQ-035 Reset asserted while PEND SHALL discard the buffered target.
REQ-036 First fetch after reset release SHALL be RESET_PC, then RESET_PC+4 absent redirects.

Verification
REQ-037 Reset, no stall, NPCOp=000 for 3 cycles -> F_PC 0x3000,0x3004,0x3008; redirect=0.
REQ-038 D_PC=0x3010, NPCOp=001, B_JP=1, IR26[15:0]=0xFFFE -> next F_PC=0x300C, redirect=1; with B_JP=0 -> F_PC+4.
REQ-039 stall=1 with NPCOp=011, RSdata=0x3400 for one cycle, then stall=1 two cycles, then stall=0 -> pend_valid=1 during stall, F_PC held, then F_PC=0x3400, pend_valid=0.
REQ-040 While PEND, exc_req=1 and eret_req=1 with EPC=0x3020 -> F_PC=0x4180, pend_valid=0.
REQ-041 NPCOp=011, RSdata=0x3002 -> F_PC=0x3002, fetch_err=1; RSdata=0x7000 -> fetch_err=1.
REQ-042 reset=0 asserted while pend_valid=1 -> F_PC=0x3000, pend_valid=0 next cycle.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator: next-PC selection with exception/eret redirect,
// a one-entry buffer for decode redirects that arrive while fetch is stalled.
module pc_gen #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
    parameter logic [WIDTH-1:0] ADDR_LO  = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] ADDR_HI  = WIDTH'(32'h0000_6FFC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] D_PC,
    input  logic [2:0]       NPCOp,
    input  logic             B_JP,
    input  logic [WIDTH-1:0] RSdata,
    input  logic [25:0]      IR26,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] EPC,
    output logic [WIDTH-1:0] F_PC,
    output logic [WIDTH-1:0] PC8,
    output logic             redirect,
    output logic             pend_valid,
    output logic             fetch_err
);

    localparam int unsigned EXT_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc_q, pc_next;
    logic [WIDTH-1:0] buf_q, buf_next;
    logic             redirect_q, redirect_next;
    logic             live_redir;
    logic [WIDTH-1:0] target;

    // Decode target; j/jal built at 64 bits so any WIDTH in 16..64 truncates cleanly
    always_comb begin
        target     = D_PC + WIDTH'(4);
        live_redir = 1'b0;
        case (NPCOp)
            3'b001: begin
                target     = D_PC + WIDTH'(4)
                           + WIDTH'({{(EXT_W-18){IR26[15]}}, IR26[15:0], 2'b00});
                live_redir = B_JP;
            end
            3'b010: begin
                target     = WIDTH'((EXT_W'(D_PC) & ~EXT_W'(64'h0FFF_FFFF))
                                    | EXT_W'({IR26, 2'b00}));
                live_redir = 1'b1;
            end
            3'b011: begin
                target     = RSdata;
                live_redir = 1'b1;
            end
            default: begin
                target     = D_PC + WIDTH'(4);
                live_redir = 1'b0;
            end
        endcase
    end

    // Next-PC selection: exc > eret > buffered > live decode > sequential
    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        buf_next      = buf_q;
        redirect_next = 1'b0;
        if (exc_req) begin
            pc_next       = EXC_PC;
            redirect_next = 1'b1;
            state_next    = IDLE;
        end else if (eret_req) begin
            pc_next       = EPC;
            redirect_next = 1'b1;
            state_next    = IDLE;
        end else if (stall) begin
            if (state == IDLE && live_redir) begin
                buf_next   = target;
                state_next = PEND;
            end
        end else if (state == PEND) begin
            // Buffered target wins; this cycle's live redirect is dropped
            pc_next       = buf_q;
            redirect_next = 1'b1;
            state_next    = IDLE;
        end else if (live_redir) begin
            pc_next       = target;
            redirect_next = 1'b1;
        end else begin
            pc_next       = pc_q + WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            buf_q      <= buf_next;
            redirect_q <= redirect_next;
        end
    end

    assign F_PC       = pc_q;
    assign redirect   = redirect_q;
    assign pend_valid = (state == PEND);
    assign PC8        = D_PC + WIDTH'(8);
    assign fetch_err  = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a behavioural next-PC model.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] d_pc;
    logic [2:0]  npcop;
    logic        b_jp;
    logic [31:0] rs_data;
    logic [25:0] ir26;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] f_pc;
    logic [31:0] pc8;
    logic        redirect;
    logic        pend_valid;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_redir;

    pc_gen dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .D_PC       (d_pc),
        .NPCOp      (npcop),
        .B_JP       (b_jp),
        .RSdata     (rs_data),
        .IR26       (ir26),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .EPC        (epc),
        .F_PC       (f_pc),
        .PC8        (pc8),
        .redirect   (redirect),
        .pend_valid (pend_valid),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_target();
        int off;
        off = int'($signed(ir26[15:0])) * 4;
        case (npcop)
            3'd1:    return d_pc + 32'd4 + 32'(off);
            3'd2:    return (d_pc & 32'hF000_0000) | (32'(ir26) * 32'd4);
            3'd3:    return rs_data;
            default: return d_pc + 32'd4;
        endcase
    endfunction

    function automatic logic model_ferr(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic live;
        live = (npcop == 3'd2) || (npcop == 3'd3) || (npcop == 3'd1 && b_jp);
        if (!reset) begin
            m_pc = 32'h3000; m_pend = 1'b0; m_redir = 1'b0;
        end else if (exc_req) begin
            m_pc = 32'h4180; m_pend = 1'b0; m_redir = 1'b1;
        end else if (eret_req) begin
            m_pc = epc; m_pend = 1'b0; m_redir = 1'b1;
        end else if (stall) begin
            m_redir = 1'b0;
            if (!m_pend && live) begin
                m_pend = 1'b1; m_tgt = model_target();
            end
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0; m_redir = 1'b1;
        end else if (live) begin
            m_pc = model_target(); m_redir = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_redir = 1'b0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; stall = 1'b0; d_pc = 32'h3000; npcop = 3'd0; b_jp = 1'b0;
        rs_data = 32'h0; ir26 = 26'h0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0; exc_req = 1'b1; npcop = 3'd3; rs_data = 32'h5000;
        cycle();
        n_tests++; if (f_pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", f_pc, 32'h3000); end
        n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", pend_valid); end
        idle_inputs();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
        idle_inputs();
        reset = 1'b0; cycle(); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cycle();
            n_tests++; if (f_pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, f_pc, exp_pc[i]); end
            n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL seq_redirect[%0d]: got %b want 0", i, redirect); end
        end
        d_pc = 32'h1234_5678;
        #1;
        n_tests++; if (pc8 !== 32'h1234_5680) begin n_fail++; $display("FAIL pc8: got %h want %h", pc8, 32'h1234_5680); end
        idle_inputs();
    endtask

    task automatic test_branch();
        d_pc = 32'h3010; npcop = 3'd1; b_jp = 1'b1; ir26 = 26'h000_FFFE;
        cycle();
        n_tests++; if (f_pc !== 32'h300C) begin n_fail++; $display("FAIL branch_taken_pc: got %h want %h", f_pc, 32'h300C); end
        n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL branch_taken_redirect: got %b want 1", redirect); end
        b_jp = 1'b0;
        cycle();
        n_tests++; if (f_pc !== 32'h3010) begin n_fail++; $display("FAIL branch_not_taken_pc: got %h want %h", f_pc, 32'h3010); end
        n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken_redirect: got %b want 0", redirect); end
        d_pc = 32'h5000_3000; npcop = 3'd2; ir26 = 26'h000_0D00;
        cycle();
        n_tests++; if (f_pc !== 32'h5000_3400) begin n_fail++; $display("FAIL jump_pc: got %h want %h", f_pc, 32'h5000_3400); end
        idle_inputs();
        npcop = 3'd3; rs_data = 32'h3010;
        cycle();
        idle_inputs();
    endtask

    task automatic test_stall_buffer();
        logic [31:0] held;
        held = m_pc;
        stall = 1'b1; npcop = 3'd3; rs_data = 32'h3400;
        cycle();
        n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_capture_pend: got %b want 1", pend_valid); end
        n_tests++; if (f_pc !== held) begin n_fail++; $display("FAIL stall_hold0: got %h want %h", f_pc, held); end
        npcop = 3'd0;
        cycle();
        npcop = 3'd3; rs_data = 32'h3800;
        cycle();
        n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pend_held: got %b want 1", pend_valid); end
        n_tests++; if (f_pc !== held) begin n_fail++; $display("FAIL stall_hold2: got %h want %h", f_pc, held); end
        stall = 1'b0; npcop = 3'd2; d_pc = 32'h3000; ir26 = 26'h000_1000;
        cycle();
        n_tests++; if (f_pc !== 32'h3400) begin n_fail++; $display("FAIL buffer_consume_pc: got %h want %h", f_pc, 32'h3400); end
        n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL buffer_consume_pend: got %b want 0", pend_valid); end
        n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL buffer_consume_redirect: got %b want 1", redirect); end
        idle_inputs();
    endtask

    task automatic test_exc_eret();
        stall = 1'b1; npcop = 3'd3; rs_data = 32'h3500;
        cycle();
        exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3020;
        cycle();
        n_tests++; if (f_pc !== 32'h4180) begin n_fail++; $display("FAIL exc_pc: got %h want %h", f_pc, 32'h4180); end
        n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL exc_pend_clear: got %b want 0", pend_valid); end
        n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL exc_redirect: got %b want 1", redirect); end
        exc_req = 1'b0; stall = 1'b0; npcop = 3'd0;
        cycle();
        n_tests++; if (f_pc !== 32'h3020) begin n_fail++; $display("FAIL eret_pc: got %h want %h", f_pc, 32'h3020); end
        eret_req = 1'b0;
        cycle();
        n_tests++; if (f_pc !== 32'h3024 || redirect !== 1'b0) begin n_fail++; $display("FAIL eret_then_seq: got %h/%b want %h/0", f_pc, redirect, 32'h3024); end
        idle_inputs();
    endtask

    task automatic test_fetch_err();
        logic [31:0] addrs [5];
        logic        errs  [5];
        addrs[0] = 32'h3002; errs[0] = 1'b1;
        addrs[1] = 32'h7000; errs[1] = 1'b1;
        addrs[2] = 32'h6FFC; errs[2] = 1'b0;
        addrs[3] = 32'h2FFC; errs[3] = 1'b1;
        addrs[4] = 32'h3000; errs[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            npcop = 3'd3; rs_data = addrs[i];
            cycle();
            n_tests++; if (f_pc !== addrs[i] || fetch_err !== errs[i]) begin
                n_fail++; $display("FAIL fetch_err[%0d]: got pc=%h err=%b want pc=%h err=%b", i, f_pc, fetch_err, addrs[i], errs[i]);
            end
        end
        npcop = 3'd3; rs_data = 32'h3002;
        cycle();
        npcop = 3'd0;
        cycle();
        n_tests++; if (f_pc !== 32'h3006) begin n_fail++; $display("FAIL misaligned_seq: got %h want %h", f_pc, 32'h3006); end
        npcop = 3'd3; rs_data = 32'hFFFF_FFFC;
        cycle();
        npcop = 3'd0;
        cycle();
        n_tests++; if (f_pc !== 32'h0 || redirect !== 1'b0 || fetch_err !== 1'b1) begin
            n_fail++; $display("FAIL wrap: got pc=%h redir=%b err=%b want pc=00000000 redir=0 err=1", f_pc, redirect, fetch_err);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_pend();
        stall = 1'b1; npcop = 3'd3; rs_data = 32'h3600;
        cycle();
        reset = 1'b0;
        cycle();
        n_tests++; if (f_pc !== 32'h3000 || pend_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_pend: got pc=%h pend=%b want pc=00003000 pend=0", f_pc, pend_valid);
        end
        idle_inputs();
        cycle();
        n_tests++; if (f_pc !== 32'h3004 || redirect !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard_buffer: got pc=%h redir=%b want pc=00003004 redir=0", f_pc, redirect);
        end
    endtask

    task automatic test_random();
        int errs_here;
        errs_here = 0;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) != 0);
            stall    = ($urandom_range(0, 2) == 0);
            exc_req  = ($urandom_range(0, 24) == 0);
            eret_req = ($urandom_range(0, 24) == 0);
            npcop    = 3'($urandom_range(0, 7));
            b_jp     = 1'($urandom);
            d_pc     = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            rs_data  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            ir26     = 26'($urandom);
            epc      = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            cycle();
            n_tests++;
            if (f_pc !== m_pc || pend_valid !== m_pend || redirect !== m_redir
                || fetch_err !== model_ferr(m_pc) || pc8 !== d_pc + 32'd8) begin
                n_fail++;
                if (errs_here < 10)
                    $display("FAIL random[%0d]: got pc=%h pend=%b redir=%b err=%b pc8=%h want pc=%h pend=%b redir=%b err=%b pc8=%h",
                             i, f_pc, pend_valid, redirect, fetch_err, pc8,
                             m_pc, m_pend, m_redir, model_ferr(m_pc), d_pc + 32'd8);
                errs_here++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_redir = 1'b0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall_buffer();
        test_exc_eret();
        test_fetch_err();
        test_reset_in_pend();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
